// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the RV32I execution sequencer: opcodes, funct3
// codes, instruction field positions, FSM state encoding and small helpers.
// Optional build macro used by the top: EXEC_SEQUENCER_RETIRE_COUNT_EN.
package exec_sequencer_pkg;

    // Major opcodes the sequencer can execute
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    // funct3 codes shared with the alu
    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SLT     = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
    localparam logic [2:0] FUNCT3_XOR     = 3'b100;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
    localparam logic [2:0] FUNCT3_OR      = 3'b110;
    localparam logic [2:0] FUNCT3_AND     = 3'b111;

    // Instruction field bit ranges
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;

    typedef enum logic [2:0] {
        FETCH      = 3'd0,
        FETCH_WAIT = 3'd1,
        DECODE     = 3'd2,
        EXECUTE    = 3'd3,
        WRITEBACK  = 3'd4,
        HALT       = 3'd5
    } state_e;

    // Memory delivers words in big-endian byte order; reverse into the IR.
    function automatic logic [31:0] byte_swap32(input logic [31:0] word);
        return {word[7:0], word[15:8], word[23:16], word[31:24]};
    endfunction

    // Only register-register and register-immediate ALU ops are executable.
    function automatic logic is_supported_opcode(input logic [6:0] opcode);
        logic ok;
        if ((opcode == OPCODE_OP_IMM) || (opcode == OPCODE_OP)) begin
            ok = 1'b1;
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/exec_sequencer_fetch_unit.sv
// Instruction fetch: drives the imem req/ack handshake, counts wait cycles
// for the bus-error timeout and byte-swaps the accepted word into the IR.
module exec_sequencer_fetch_unit
    import exec_sequencer_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        waiting,
    input  logic [31:0] fetch_pc,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] ir,
    output logic        fetch_done,
    output logic        fetch_timeout
);

    // Counter only needs to reach FETCH_TIMEOUT-1; the cycle after that halts.
    localparam int CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt_r;
    logic             imem_req_r;
    logic [31:0]      imem_addr_r;
    logic [31:0]      ir_r;

    // An ack arriving on the timeout cycle takes priority over the timeout.
    assign fetch_done    = waiting & imem_ack;
    assign fetch_timeout = waiting & ~imem_ack & (wait_cnt_r == CNT_LAST);

    assign imem_req  = imem_req_r;
    assign imem_addr = imem_addr_r;
    assign ir        = ir_r;

    // Handshake, wait counter and instruction register update
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            imem_req_r  <= 1'b0;
            imem_addr_r <= 32'h0000_0000;
            ir_r        <= 32'h0000_0000;
            wait_cnt_r  <= {CNT_W{1'b0}};
        end else if (start) begin
            imem_req_r  <= 1'b1;
            imem_addr_r <= fetch_pc;
            wait_cnt_r  <= {CNT_W{1'b0}};
        end else if (fetch_done) begin
            imem_req_r <= 1'b0;
            ir_r       <= byte_swap32(imem_data);
        end else if (fetch_timeout) begin
            imem_req_r <= 1'b0;
        end else if (waiting) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            imem_req_r <= 1'b0;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle control FSM for the RV32I core: fetch, decode, execute on the
// external alu, write back to the external register file.
// Build macro EXEC_SEQUENCER_RETIRE_COUNT_EN adds a 64-bit retired
// instruction counter on output port instret.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [4:0]  rf_rs1_addr,
    output logic [4:0]  rf_rs2_addr,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    output logic        rf_we,
    output logic [4:0]  rf_rd_addr,
    output logic [31:0] rf_wd,
    output logic [31:0] alu_instruction,
    output logic [31:0] alu_op_a,
    output logic [31:0] alu_op_b,
    input  logic [31:0] alu_out,
    output logic [31:0] pc,
    output logic        halted,
    output logic        illegal,
    output logic        bus_error
`ifdef EXEC_SEQUENCER_RETIRE_COUNT_EN
    ,
    output logic [63:0] instret
`endif
);

    state_e      state_r;
    logic [31:0] pc_r;
    logic [31:0] result_r;
    logic [31:0] alu_instr_r;
    logic [31:0] op_a_hold_r;
    logic [31:0] op_b_hold_r;
    logic        rf_we_r;
    logic [4:0]  rf_rd_addr_r;
    logic        halted_r;
    logic        illegal_r;
    logic        bus_error_r;
    logic [31:0] ir_s;
    logic        fetch_done_s;
    logic        fetch_timeout_s;
    logic        fetch_start_s;
    logic        fetch_waiting_s;
    logic [31:0] alu_op_a_s;
    logic [31:0] alu_op_b_s;
`ifdef EXEC_SEQUENCER_RETIRE_COUNT_EN
    logic [63:0] instret_r;
    assign instret = instret_r;
`endif

    assign fetch_start_s   = (state_r == FETCH);
    assign fetch_waiting_s = (state_r == FETCH_WAIT);

    exec_sequencer_fetch_unit #(
        .FETCH_TIMEOUT (FETCH_TIMEOUT)
    ) u_fetch (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (fetch_start_s),
        .waiting       (fetch_waiting_s),
        .fetch_pc      (pc_r),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .ir            (ir_s),
        .fetch_done    (fetch_done_s),
        .fetch_timeout (fetch_timeout_s)
    );

    // Operands follow the register file live in EXECUTE and hold otherwise
    always_comb begin
        alu_op_a_s = op_a_hold_r;
        alu_op_b_s = op_b_hold_r;
        if (state_r == EXECUTE) begin
            alu_op_a_s = rf_rs1_data;
            alu_op_b_s = rf_rs2_data;
        end else begin
            alu_op_a_s = op_a_hold_r;
            alu_op_b_s = op_b_hold_r;
        end
    end

    assign rf_rs1_addr     = ir_s[RS1_MSB:RS1_LSB];
    assign rf_rs2_addr     = ir_s[RS2_MSB:RS2_LSB];
    assign rf_we           = rf_we_r;
    assign rf_rd_addr      = rf_rd_addr_r;
    assign rf_wd           = result_r;
    assign alu_instruction = alu_instr_r;
    assign alu_op_a        = alu_op_a_s;
    assign alu_op_b        = alu_op_b_s;
    assign pc              = pc_r;
    assign halted          = halted_r;
    assign illegal         = illegal_r;
    assign bus_error       = bus_error_r;

    // Sequencer FSM with registered control and status outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= FETCH;
            pc_r         <= RESET_PC;
            result_r     <= 32'h0000_0000;
            alu_instr_r  <= 32'h0000_0000;
            op_a_hold_r  <= 32'h0000_0000;
            op_b_hold_r  <= 32'h0000_0000;
            rf_we_r      <= 1'b0;
            rf_rd_addr_r <= 5'd0;
            halted_r     <= 1'b0;
            illegal_r    <= 1'b0;
            bus_error_r  <= 1'b0;
`ifdef EXEC_SEQUENCER_RETIRE_COUNT_EN
            instret_r    <= 64'd0;
`endif
        end else begin
            case (state_r)
                FETCH: begin
                    state_r <= FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    if (fetch_done_s) begin
                        state_r <= DECODE;
                    end else if (fetch_timeout_s) begin
                        state_r     <= HALT;
                        bus_error_r <= 1'b1;
                        halted_r    <= 1'b1;
                    end else begin
                        state_r <= FETCH_WAIT;
                    end
                end
                DECODE: begin
                    if (is_supported_opcode(ir_s[OPCODE_MSB:OPCODE_LSB])) begin
                        alu_instr_r <= ir_s;
                        state_r     <= EXECUTE;
                    end else begin
                        illegal_r <= 1'b1;
                        halted_r  <= 1'b1;
                        state_r   <= HALT;
                    end
                end
                EXECUTE: begin
                    result_r     <= alu_out;
                    op_a_hold_r  <= rf_rs1_data;
                    op_b_hold_r  <= rf_rs2_data;
                    rf_rd_addr_r <= ir_s[RD_MSB:RD_LSB];
                    // x0 is hardwired to zero, so never pulse a write to it
                    rf_we_r      <= (ir_s[RD_MSB:RD_LSB] != 5'd0);
                    state_r      <= WRITEBACK;
                end
                WRITEBACK: begin
                    rf_we_r   <= 1'b0;
                    pc_r      <= pc_r + 32'd4;
`ifdef EXEC_SEQUENCER_RETIRE_COUNT_EN
                    instret_r <= instret_r + 64'd1;
`endif
                    state_r   <= FETCH;
                end
                HALT: begin
                    rf_we_r <= 1'b0;
                    state_r <= HALT;
                end
                default: begin
                    // Corrupted state encoding: stop the core safely
                    rf_we_r  <= 1'b0;
                    halted_r <= 1'b1;
                    state_r  <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed and random instructions
// checked against a behavioural model of the RV32I ALU ops and sequencing.
// Build macro EXEC_SEQUENCER_RETIRE_COUNT_EN enables the instret checks.
module tb_exec_sequencer;

    localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;
    localparam int          TB_TIMEOUT  = 4;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [4:0]  rf_rs1_addr;
    logic [4:0]  rf_rs2_addr;
    logic [31:0] rf_rs1_data;
    logic [31:0] rf_rs2_data;
    logic        rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_wd;
    logic [31:0] alu_instruction;
    logic [31:0] alu_op_a;
    logic [31:0] alu_op_b;
    logic [31:0] alu_out;
    logic [31:0] pc;
    logic        halted;
    logic        illegal;
    logic        bus_error;
`ifdef EXEC_SEQUENCER_RETIRE_COUNT_EN
    logic [63:0] instret;
`endif

    int          n_checks;
    int          n_errors;
    logic [31:0] pc_model;
    logic [63:0] instret_model;

    exec_sequencer #(
        .RESET_PC      (TB_RESET_PC),
        .FETCH_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_data       (imem_data),
        .rf_rs1_addr     (rf_rs1_addr),
        .rf_rs2_addr     (rf_rs2_addr),
        .rf_rs1_data     (rf_rs1_data),
        .rf_rs2_data     (rf_rs2_data),
        .rf_we           (rf_we),
        .rf_rd_addr      (rf_rd_addr),
        .rf_wd           (rf_wd),
        .alu_instruction (alu_instruction),
        .alu_op_a        (alu_op_a),
        .alu_op_b        (alu_op_b),
        .alu_out         (alu_out),
        .pc              (pc),
        .halted          (halted),
        .illegal         (illegal),
        .bus_error       (bus_error)
`ifdef EXEC_SEQUENCER_RETIRE_COUNT_EN
        ,
        .instret         (instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32I integer ALU semantics for OP and OP-IMM
    function automatic logic [31:0] alu_model(input logic [31:0] ins, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] y;
        logic        is_op;
        is_op = (ins[6:0] == 7'b0110011);
        y = is_op ? b : {{20{ins[31]}}, ins[31:20]};
        case (ins[14:12])
            3'd0:    return (is_op && ins[30]) ? a - y : a + y;
            3'd1:    return a << y[4:0];
            3'd2:    return {31'd0, ($signed(a) < $signed(y))};
            3'd3:    return {31'd0, (a < y)};
            3'd4:    return a ^ y;
            3'd5:    return ins[30] ? 32'($signed(a) >>> y[4:0]) : a >> y[4:0];
            3'd6:    return a | y;
            default: return a & y;
        endcase
    endfunction

    // Combinational ALU seen by the DUT
    always_comb alu_out = alu_model(alu_instruction, alu_op_a, alu_op_b);

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_legal_instr();
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        f3  = 3'($urandom_range(0, 7));
        f7  = (((f3 == 3'd0) || (f3 == 3'd5)) && ($urandom_range(0, 1) == 1)) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 1) == 1) begin
            return {f7, rs2, rs1, f3, rd, 7'b0110011};
        end
        imm = 12'($urandom);
        if (f3 == 3'd1) imm = {7'h00, rs2};
        if (f3 == 3'd5) imm = {f7, rs2};
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Sync reset held two edges; an ack during reset must be ignored
    task automatic do_reset();
        reset_n   = 1'b0;
        imem_ack  = 1'b1;
        imem_data = 32'hDEAD_BEEF;
        step();
        step();
        check_val("rst_req", imem_req, 1'b0);
        check_val("rst_we", rf_we, 1'b0);
        check_val("rst_pc", pc, TB_RESET_PC);
        check_val("rst_addr", imem_addr, 32'd0);
        check_val("rst_flags", {halted, illegal, bus_error}, 3'b000);
        check_val("rst_rs1", rf_rs1_addr, 5'd0);
        check_val("rst_opa", alu_op_a, 32'd0);
        reset_n       = 1'b1;
        imem_ack      = 1'b0;
        pc_model      = TB_RESET_PC;
        instret_model = 64'd0;
    endtask

    // One instruction from the FETCH cycle through to the next FETCH cycle
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                             input int dly);
        logic        legal;
        logic [31:0] exp_wd;
        legal       = (ins[6:0] == 7'b0010011) || (ins[6:0] == 7'b0110011);
        exp_wd      = alu_model(ins, a, b);
        rf_rs1_data = a;
        rf_rs2_data = b;
        imem_data   = {<<8{ins}};
        step();
        check_val("fw_req", imem_req, 1'b1);
        check_val("fw_addr", imem_addr, pc_model);
        for (int i = 0; i < dly; i++) begin
            imem_ack = 1'b0;
            step();
            check_val("fw_hold", {imem_req, halted}, 2'b10);
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check_val("dec_req", imem_req, 1'b0);
        check_val("dec_rs", {rf_rs1_addr, rf_rs2_addr}, {ins[19:15], ins[24:20]});
        step();
        if (!legal) begin
            check_val("ill_flags", {halted, illegal, bus_error}, 3'b110);
            check_val("ill_pc", pc, pc_model);
            check_val("ill_out", {imem_req, rf_we}, 2'b00);
`ifdef EXEC_SEQUENCER_RETIRE_COUNT_EN
            check_val("ill_instret", instret, instret_model);
`endif
            return;
        end
        check_val("ex_instr", alu_instruction, ins);
        check_val("ex_ops", {alu_op_a, alu_op_b}, {a, b});
        check_val("ex_we", rf_we, 1'b0);
        step();
        check_val("wb_we", rf_we, (ins[11:7] != 5'd0));
        check_val("wb_rd", rf_rd_addr, ins[11:7]);
        check_val("wb_wd", rf_wd, exp_wd);
        pc_model      = pc_model + 32'd4;
        instret_model = instret_model + 64'd1;
        step();
        check_val("nf_pc", pc, pc_model);
        check_val("nf_out", {imem_req, rf_we, halted}, 3'b000);
`ifdef EXEC_SEQUENCER_RETIRE_COUNT_EN
        check_val("instret", instret, instret_model);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset_n     = 1'b0;
        imem_ack    = 1'b0;
        imem_data   = 32'd0;
        rf_rs1_data = 32'd0;
        rf_rs2_data = 32'd0;
        do_reset();

        // Directed: ADDI/ADDI -1/SLTI/ADDI x0; pc wraps through zero
        run_instr(32'h0010_0093, 32'd1, 32'd0, 0);
        run_instr(32'hFFF0_0113, 32'd1, 32'd7, 0);
        run_instr(32'h0000_2193, 32'hFFFF_FFFF, 32'd0, 1);
        run_instr(32'h0050_0013, 32'd3, 32'd0, 0);
        // Ack arriving on the last permitted wait cycle
        run_instr(32'h0020_81B3, 32'd10, 32'd20, TB_TIMEOUT - 1);

        // Random legal instructions with random operands and ack latency
        for (int n = 0; n < 24; n++) begin
            run_instr(rand_legal_instr(), $urandom, $urandom, $urandom_range(0, TB_TIMEOUT - 1));
        end

        // Branch opcode halts; subsequent acks do nothing
        run_instr(32'h0000_0063, 32'd5, 32'd6, 0);
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("halt_sticky", {halted, illegal, imem_req, rf_we}, 4'b1100);
            check_val("halt_pc", pc, pc_model);
        end
        imem_ack = 1'b0;

        // Fetch timeout with no ack
        do_reset();
        step();
        for (int i = 1; i < TB_TIMEOUT; i++) begin
            step();
            check_val("to_wait", {imem_req, halted}, 2'b10);
        end
        step();
        check_val("to_flags", {halted, illegal, bus_error}, 3'b101);
        check_val("to_req", imem_req, 1'b0);
        check_val("to_pc", pc, TB_RESET_PC);

        // Reset during FETCH_WAIT with ack asserted
        do_reset();
        step();
        check_val("rw_req", imem_req, 1'b1);
        reset_n  = 1'b0;
        imem_ack = 1'b1;
        step();
        check_val("rw_out", {imem_req, rf_we, halted}, 3'b000);
        check_val("rw_pc", pc, TB_RESET_PC);
        reset_n  = 1'b1;
        imem_ack = 1'b0;
        run_instr(32'h0030_8093, 32'd40, 32'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
